// File: rtl/mem_read_ctrl.sv
// Read controller: captures an address, strobes memory until it acks, then holds the word for the consumer.
// Optional `MEM_READ_TIMEOUT_EN` bounds the wait and aborts to HOLD with ERR_DATA and err raised.
module mem_read_ctrl #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        o_busy,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [15:0] o_data_out,
    output logic        o_data_valid,
    input  logic        i_data_taken,
    output logic        o_err
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_mem_rd;
    logic        r_data_valid;
    logic [15:0] r_mem_addr;
    logic [15:0] r_data_out;

`ifdef MEM_READ_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    // Abort fires on the edge that would make the count equal TIMEOUT (TIMEOUT >= 1).
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_data_valid <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_data_out   <= 16'h0000;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_mem_addr <= i_addr;
                        r_state    <= StReq;
                        r_busy     <= 1'b1;
                        r_mem_rd   <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                StReq: begin
                    // A late ack still beats the abort in the limit cycle.
                    if (i_mem_ack) begin
                        r_data_out   <= i_mem_data;
                        r_state      <= StHold;
                        r_mem_rd     <= 1'b0;
                        r_data_valid <= 1'b1;
                    end else if (r_cnt == CntLast) begin
                        r_data_out   <= ERR_DATA;
                        r_state      <= StHold;
                        r_mem_rd     <= 1'b0;
                        r_data_valid <= 1'b1;
                        r_err        <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (i_data_taken) begin
                        r_data_valid <= 1'b0;
                        r_err        <= 1'b0;
                        if (i_req) begin
                            r_mem_addr <= i_addr;
                            r_state    <= StReq;
                            r_mem_rd   <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_busy       <= 1'b0;
                    r_mem_rd     <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_err        <= 1'b0;
                end
            endcase
        end
    end

    assign o_err = r_err;
`else
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_data_valid <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_data_out   <= 16'h0000;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_mem_addr <= i_addr;
                        r_state    <= StReq;
                        r_busy     <= 1'b1;
                        r_mem_rd   <= 1'b1;
                    end
                end
                StReq: begin
                    if (i_mem_ack) begin
                        r_data_out   <= i_mem_data;
                        r_state      <= StHold;
                        r_mem_rd     <= 1'b0;
                        r_data_valid <= 1'b1;
                    end
                end
                StHold: begin
                    if (i_data_taken) begin
                        r_data_valid <= 1'b0;
                        if (i_req) begin
                            r_mem_addr <= i_addr;
                            r_state    <= StReq;
                            r_mem_rd   <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_busy       <= 1'b0;
                    r_mem_rd     <= 1'b0;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    // Timeout parameters only matter when the abort path is built.
    logic w_unused_cfg;
    assign w_unused_cfg = (^ERR_DATA) ^ (TIMEOUT != 0);

    assign o_err = 1'b0;
`endif

    assign o_busy       = r_busy;
    assign o_mem_rd     = r_mem_rd;
    assign o_mem_addr   = r_mem_addr;
    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;

endmodule

// File: doc/mem_read_ctrl.md
MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum REQ-state cycles without mem_ack before abort (used only under REQ-027).
REQ-002 Parameter ERR_DATA, default 16'hFFFF: value loaded into data_out on a timeout abort.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  read request from the control unit; sampled only in IDLE.
REQ-006 addr  input  16  read address; captured on an accepted req.
REQ-007 busy  output  1  high in REQ and HOLD.
REQ-008 mem_rd  output  1  memory read strobe; high only in REQ.
REQ-009 mem_addr  output  16  captured address, held stable while mem_rd=1.
REQ-010 mem_ack  input  1  memory data-ready; sampled only in REQ.
REQ-011 mem_data  input  16  read data; valid when mem_ack=1.
REQ-012 data_out  output  16  registered read word, presented to the B/A source muxes.
REQ-013 data_valid  output  1  data_out holds a fresh word (HOLD state).
REQ-014 data_taken  input  1  consumer accepted data_out (driven from b_write/a_write path).
REQ-015 err  output  1  timeout flag; constant 0 when MEM_READ_TIMEOUT_EN is undefined.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD; encoding is free.
REQ-017 IDLE: on req=1, addr SHALL be captured into mem_addr and the state SHALL become REQ on the next edge.
REQ-018 REQ: mem_rd SHALL be 1; on mem_ack=1, mem_data SHALL be captured into data_out and the state SHALL become HOLD.
REQ-019 HOLD: data_valid SHALL be 1 and data_out SHALL be held; on data_taken=1 the state SHALL become IDLE.
REQ-020 HOLD with data_taken=1 and req=1 in the same cycle: addr SHALL be captured and the state SHALL go directly to REQ (back-to-back reads, no IDLE cycle).
REQ-021 req outside IDLE (except REQ-020) SHALL be ignored; no queueing.
REQ-022 mem_ack outside REQ and data_taken outside HOLD SHALL be ignored.
REQ-023 Latency: req accepted at edge n gives mem_rd=1 in cycle n+1; mem_ack sampled at edge m gives data_valid=1 and data_out=mem_data from cycle m+1; minimum req-to-valid latency is 2 cycles.
REQ-024 mem_addr SHALL change only on address capture; data_out SHALL change only on capture, abort, or reset.
REQ-025 All outputs SHALL be registered or decoded from state only; no combinational path from any input to any output.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE, mem_rd=0, busy=0, data_valid=0, err=0, mem_addr=16'h0000, data_out=16'h0000, timeout count=0, from any state including mid-REQ; reset has priority over all inputs.

Configuration
REQ-027 Macro MEM_READ_TIMEOUT_EN defined: a counter SHALL clear on entering REQ and increment each REQ cycle without mem_ack; when it reaches TIMEOUT, the state SHALL go to HOLD with data_out=ERR_DATA and err=1; err SHALL clear when HOLD is left; mem_ack in the same cycle as the limit SHALL win (normal capture, err=0).
REQ-028 Macro MEM_READ_TIMEOUT_EN undefined: no counter is built, REQ waits indefinitely for mem_ack, err is tied to 0.

Verification
REQ-029 Reset, then req=1 addr=16'h0040, mem_ack=1 mem_data=16'hBEEF in the first REQ cycle -> mem_rd one cycle, mem_addr=16'h0040, data_valid=1 data_out=16'hBEEF two cycles after req.
REQ-030 mem_ack delayed 3 REQ cycles with mem_data=16'h1234 -> mem_rd high 3 cycles, mem_addr stable, data_out=16'h1234 after ack; req pulses during REQ/HOLD ignored.
REQ-031 In HOLD, data_taken=1 with req=1 addr=16'h0081 -> next cycle REQ with mem_addr=16'h0081, data_valid=0.
REQ-032 reset=1 during REQ with mem_ack=1 -> next cycle IDLE, data_out=16'h0000, data_valid=0, mem_rd=0.
REQ-033 MEM_READ_TIMEOUT_EN, TIMEOUT=15, no mem_ack -> after 15 REQ cycles data_out=16'hFFFF, err=1, data_valid=1; data_taken=1 clears err; undefined build: mem_rd stays high, err=0.
REQ-034 MEM_READ_TIMEOUT_EN, mem_ack arrives in the cycle the count reaches TIMEOUT -> normal capture, err=0.
